// File: rtl/rtc_bus_sched.sv
// Round-robin owner of the shared RTC parallel bus: one request at a time, sequenced as
// address setup, fixed-width RD/WR strobe, hold, then a done pulse to the owner.
module rtc_bus_sched #(
  parameter int STROBE_CYCLES = 256,
  parameter int NREQ          = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [8*NREQ-1:0]    req_addr,
  input  logic [8*NREQ-1:0]    req_wdata,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [7:0]           rdata,
  output logic [7:0]           dir_out,
  output logic [7:0]           bus_wdata,
  input  logic [7:0]           bus_rdata,
  output logic                 RD,
  output logic                 WR,
  output logic                 busy
);
  localparam int CW = $clog2(STROBE_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      own_q, own_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            op_q, op_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      dir_q, dir_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            busy_q, busy_d;

  logic            win_vld;
  logic [1:0]      win_idx;
  logic [1:0]      idx;

  // Scan from the lowest priority upward so the requester closest to ptr wins last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    idx     = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    grant_d = grant_q;
    done_d  = '0;
    rdata_d = rdata_q;
    dir_d   = dir_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_ADDR;
          own_d   = win_idx;
          grant_d = NREQ'(1) << win_idx;
          dir_d   = req_addr[{win_idx, 3'b000} +: 8];
          wdata_d = req_wdata[{win_idx, 3'b000} +: 8];
          op_d    = req_wr[win_idx];
          busy_d  = 1'b1;
        end
      end
      S_ADDR: begin
        state_d = S_STROBE;
        cnt_d   = CW'(STROBE_CYCLES - 1);
        rd_d    = ~op_q;
        wr_d    = op_q;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (!op_q) rdata_d = bus_rdata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        state_d = S_DONE;
        done_d  = grant_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = own_q + 2'd1;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      op_q    <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      dir_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      dir_q   <= dir_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign dir_out   = dir_q;
  assign bus_wdata = wdata_q;
  assign RD        = rd_q;
  assign WR        = wr_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_rtc_bus_sched.sv
// Directed bench for rtc_bus_sched with STROBE_CYCLES=4: idle, read, write,
// mid-strobe reset, requester drop and round-robin ordering.
module tb_rtc_bus_sched;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  grant, done;
  logic [7:0]  rdata, dir_out, bus_wdata, bus_rdata;
  logic        RD, WR, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rtc_bus_sched #(.STROBE_CYCLES(S), .NREQ(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .dir_out(dir_out), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .RD(RD), .WR(WR), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction, k counted in cycles after the arbitration edge.
  task automatic txn(input logic [3:0] g, input logic wr, input logic [7:0] addr,
                     input logic [7:0] wd, input logic [7:0] rde, input int drop_k);
    logic strobe;
    for (int k = 1; k <= S + 4; k++) begin
      step();
      if (k == drop_k) req = req & ~g;
      strobe = (k >= 2) && (k <= S + 1);
      chk("rd", {31'd0, RD}, {31'd0, strobe & ~wr});
      chk("wr", {31'd0, WR}, {31'd0, strobe & wr});
      if (k <= S + 3) begin
        chk("grant", {28'd0, grant}, {28'd0, g});
        chk("busy", {31'd0, busy}, 32'd1);
        chk("dir_out", {24'd0, dir_out}, {24'd0, addr});
        chk("bus_wdata", {24'd0, bus_wdata}, {24'd0, wd});
        chk("done", {28'd0, done}, (k == S + 3) ? {28'd0, g} : 32'd0);
        if (k >= S + 2 || wr) chk("rdata", {24'd0, rdata}, {24'd0, rde});
      end else begin
        chk("idle_grant", {28'd0, grant}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {28'd0, done}, 32'd0);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_wr    = '0;
    req_addr  = {8'h7F, 8'h41, 8'h21, 8'h10};
    req_wdata = {8'hC3, 8'h13, 8'hB1, 8'hA0};
    bus_rdata = 8'h5A;
    repeat (3) step();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_outputs", {grant, done, rdata, dir_out, bus_wdata[3:0]}, 32'd0);
      chk("idle_misc", {bus_wdata[7:4], RD, WR, busy}, 32'd0);
    end

    // single read on requester 1
    req = 4'b0010;
    txn(4'b0010, 1'b0, 8'h21, 8'hB1, 8'h5A, S + 3);

    // single write on requester 2
    req_wr = 4'b0100;
    req    = 4'b0100;
    txn(4'b0100, 1'b1, 8'h41, 8'h13, 8'h5A, S + 3);

    // reset during the second strobe cycle of a write on requester 3
    req_wr = 4'b1000;
    req    = 4'b1000;
    step(); chk("rst_addr_grant", {28'd0, grant}, 32'd8);
    step(); chk("rst_strobe1_wr", {31'd0, WR}, 32'd1);
    step(); chk("rst_strobe2_wr", {31'd0, WR}, 32'd1);
    reset = 1'b1;
    step();
    chk("rst_outputs", {grant, done, rdata, dir_out, bus_wdata[3:0]}, 32'd0);
    chk("rst_misc", {bus_wdata[7:4], RD, WR, busy}, 32'd0);
    reset = 1'b0;

    // ptr back at 0: requester 0 beats the still-pending requester 3
    req_wr    = 4'b0000;
    req       = 4'b1001;
    bus_rdata = 8'h3C;
    txn(4'b0001, 1'b0, 8'h10, 8'hA0, 8'h3C, S + 3);

    // requester 3 drops its request mid-strobe yet still completes
    bus_rdata = 8'h96;
    txn(4'b1000, 1'b0, 8'h7F, 8'hC3, 8'h96, 3);

    // all four requesting continuously
    req       = 4'b1111;
    bus_rdata = 8'h55;
    for (int k = 1; k <= 4 * (S + 4) + 1; k++) begin
      step();
      if ((k - 1) % (S + 4) == 0)
        chk("rr_grant", {28'd0, grant}, 32'(1) << (((k - 1) / (S + 4)) % 4));
      if (k % (S + 4) == S + 3)
        chk("rr_done", {28'd0, done}, 32'(1) << (k / (S + 4)));
      if (k % (S + 4) == 0) begin
        chk("rr_gap_grant", {28'd0, grant}, 32'd0);
        chk("rr_gap_busy", {31'd0, busy}, 32'd0);
      end
    end
    req = '0;
    repeat (S + 4) step();
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("final_rdata", {24'd0, rdata}, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
